// File: rtl/regread_issue_pkg.sv
// Shared types and constants for the register-read / issue stage.
package regread_issue_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // The payload travels beside this struct because its width is a module parameter.
  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       rd_we;
  } regread_req_t;

  function automatic logic wb_hit(input logic we, input logic [4:0] wb_idx,
                                  input logic [4:0] idx);
    return we && (wb_idx == idx) && (idx != REG_ZERO);
  endfunction

endpackage

// File: rtl/regread_issue_if.sv
// Decode-side request and execute-side result handshakes of the issue stage.
interface regread_issue_if #(parameter int PAYLOAD_W = 32);

  logic                 in_valid;
  logic                 in_ready;
  logic [4:0]           in_rs1_s;
  logic [4:0]           in_rs2_s;
  logic [4:0]           in_rd_s;
  logic                 in_rd_we;
  logic [PAYLOAD_W-1:0] in_payload;

  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          out_rs1_v;
  logic [31:0]          out_rs2_v;
  logic [4:0]           out_rd_s;
  logic                 out_rd_we;
  logic [PAYLOAD_W-1:0] out_payload;

  modport slave (
    input  in_valid, in_rs1_s, in_rs2_s, in_rd_s, in_rd_we, in_payload, out_ready,
    output in_ready, out_valid, out_rs1_v, out_rs2_v, out_rd_s, out_rd_we, out_payload
  );

  modport master (
    output in_valid, in_rs1_s, in_rs2_s, in_rd_s, in_rd_we, in_payload, out_ready,
    input  in_ready, out_valid, out_rs1_v, out_rs2_v, out_rd_s, out_rd_we, out_payload
  );

endinterface

// File: rtl/regread_issue_scoreboard.sv
// Busy-bit scoreboard: tracks registers with a write in flight and flags RAW/WAW hazards.
module regread_scoreboard
  import regread_issue_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         set_en,
  input  regread_req_t req,
  input  logic         wb_we,
  input  logic [4:0]   wb_rd_s,
  output logic         hz_raw,
  output logic         hz_waw
);

  logic [31:1] busy_reg;
  logic [31:0] busy;
  logic        clr1, clr2, clrd;

  // Set takes priority so a re-issued writer stays tracked past an older writeback.
  for (genvar gi = 1; gi < 32; gi++) begin : g_busy
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        busy_reg[gi] <= 1'b0;
      end else if (set_en && (req.rd == 5'(gi))) begin
        busy_reg[gi] <= 1'b1;
      end else if (wb_we && (wb_rd_s == 5'(gi))) begin
        busy_reg[gi] <= 1'b0;
      end
    end
  end

  assign busy = {busy_reg, 1'b0};

  assign clr1 = wb_we && (wb_rd_s == req.rs1);
  assign clr2 = wb_we && (wb_rd_s == req.rs2);
  assign clrd = wb_we && (wb_rd_s == req.rd);

  assign hz_raw = ((req.rs1 != REG_ZERO) && busy[req.rs1] && !clr1) ||
                  ((req.rs2 != REG_ZERO) && busy[req.rs2] && !clr2);
  assign hz_waw = req.rd_we && (req.rd != REG_ZERO) && busy[req.rd] && !clrd;

endmodule

// File: rtl/regread_issue.sv
// Register-read / issue stage with writeback forwarding and hazard scoreboard.
// Optional stall counters are built when REGREAD_STALL_CNT_EN is defined.
module regread_issue
  import regread_issue_pkg::*;
#(
  parameter int PAYLOAD_W = 32
`ifdef REGREAD_STALL_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic                clk,
  input  logic                rst,
  regread_issue_if.slave      io,
  output logic [4:0]          regf_rs1_s,
  output logic [4:0]          regf_rs2_s,
  input  logic [31:0]         regf_rs1_v,
  input  logic [31:0]         regf_rs2_v,
  input  logic                wb_we,
  input  logic [4:0]          wb_rd_s,
  input  logic [31:0]         wb_rd_v
`ifdef REGREAD_STALL_CNT_EN
  , output logic [CNT_W-1:0]  raw_stall_cnt
  , output logic [CNT_W-1:0]  waw_stall_cnt
`endif
);

  regread_req_t         req;
  regread_req_t         slot_reg;
  logic [PAYLOAD_W-1:0] payload_reg;
  logic                 valid_reg;
  logic                 fwd1_reg, fwd2_reg;
  logic [31:0]          fwd_val1_reg, fwd_val2_reg;
  logic                 hz, hz_raw, hz_waw, stall, accept;

  assign req = '{rs1: io.in_rs1_s, rs2: io.in_rs2_s, rd: io.in_rd_s, rd_we: io.in_rd_we};

  assign stall       = valid_reg && !io.out_ready;
  assign hz          = hz_raw || hz_waw;
  assign io.in_ready = !hz && !stall;
  assign accept      = io.in_valid && io.in_ready;

  // While stalled the held indices are re-read so the slot keeps seeing fresh writes.
  assign regf_rs1_s = stall ? slot_reg.rs1 : req.rs1;
  assign regf_rs2_s = stall ? slot_reg.rs2 : req.rs2;

  regread_scoreboard u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .set_en  (accept && req.rd_we && (req.rd != REG_ZERO)),
    .req     (req),
    .wb_we   (wb_we),
    .wb_rd_s (wb_rd_s),
    .hz_raw  (hz_raw),
    .hz_waw  (hz_waw)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_reg    <= 1'b0;
      slot_reg     <= '0;
      payload_reg  <= '0;
      fwd1_reg     <= 1'b0;
      fwd2_reg     <= 1'b0;
      fwd_val1_reg <= '0;
      fwd_val2_reg <= '0;
    end else begin
      // The regfile returns pre-write data when a write hits the address being read.
      fwd1_reg     <= wb_hit(wb_we, wb_rd_s, regf_rs1_s);
      fwd2_reg     <= wb_hit(wb_we, wb_rd_s, regf_rs2_s);
      fwd_val1_reg <= wb_rd_v;
      fwd_val2_reg <= wb_rd_v;
      if (accept) begin
        valid_reg   <= 1'b1;
        slot_reg    <= req;
        payload_reg <= io.in_payload;
      end else if (io.out_ready) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign io.out_valid   = valid_reg;
  assign io.out_rd_s    = slot_reg.rd;
  assign io.out_rd_we   = slot_reg.rd_we;
  assign io.out_payload = payload_reg;
  assign io.out_rs1_v   = (slot_reg.rs1 == REG_ZERO) ? 32'd0 :
                          (fwd1_reg ? fwd_val1_reg : regf_rs1_v);
  assign io.out_rs2_v   = (slot_reg.rs2 == REG_ZERO) ? 32'd0 :
                          (fwd2_reg ? fwd_val2_reg : regf_rs2_v);

`ifdef REGREAD_STALL_CNT_EN
  logic [CNT_W-1:0] raw_cnt_reg, waw_cnt_reg;

  // A request blocked by both causes is attributed to RAW only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      raw_cnt_reg <= '0;
      waw_cnt_reg <= '0;
    end else if (io.in_valid && hz_raw) begin
      if (raw_cnt_reg != '1) raw_cnt_reg <= raw_cnt_reg + 1'b1;
    end else if (io.in_valid && hz_waw) begin
      if (waw_cnt_reg != '1) waw_cnt_reg <= waw_cnt_reg + 1'b1;
    end
  end

  assign raw_stall_cnt = raw_cnt_reg;
  assign waw_stall_cnt = waw_cnt_reg;
`endif

endmodule

// File: tb/tb_regread_issue.sv
// Directed self-checking bench for regread_issue, with a synchronous-read regfile model.
module tb_regread_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        rf_clear;
  logic [4:0]  regf_rs1_s, regf_rs2_s;
  logic [31:0] regf_rs1_v, regf_rs2_v;
  logic        wb_we;
  logic [4:0]  wb_rd_s;
  logic [31:0] wb_rd_v;
`ifdef REGREAD_STALL_CNT_EN
  logic [31:0] raw_cnt, waw_cnt;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  regread_issue_if #(.PAYLOAD_W(32)) bus ();

  regread_issue #(.PAYLOAD_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .io         (bus),
    .regf_rs1_s (regf_rs1_s),
    .regf_rs2_s (regf_rs2_s),
    .regf_rs1_v (regf_rs1_v),
    .regf_rs2_v (regf_rs2_v),
    .wb_we      (wb_we),
    .wb_rd_s    (wb_rd_s),
    .wb_rd_v    (wb_rd_v)
`ifdef REGREAD_STALL_CNT_EN
    , .raw_stall_cnt (raw_cnt)
    , .waw_stall_cnt (waw_cnt)
`endif
  );

  // Regfile model: never-written registers read as 0xA50000nn so stale reads stand out.
  logic [31:0] rf_mem [32];
  logic [31:0] rf_written;

  function automatic logic [31:0] rf_peek(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (rf_written[a]) return rf_mem[a];
    return 32'hA500_0000 | 32'(a);
  endfunction

  always @(posedge clk) begin
    regf_rs1_v <= rf_peek(regf_rs1_s);
    regf_rs2_v <= rf_peek(regf_rs2_s);
    if (rf_clear) begin
      rf_written <= '0;
    end else if (wb_we && wb_rd_s != 5'd0) begin
      rf_mem[wb_rd_s]     <= wb_rd_v;
      rf_written[wb_rd_s] <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst && bus.out_valid && bus.out_ready)
      $display("xfer payload=%h rs1_v=%h rs2_v=%h rd=%0d", bus.out_payload,
               bus.out_rs1_v, bus.out_rs2_v, bus.out_rd_s);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid   = 1'b0;
    bus.in_rs1_s   = 5'd0;
    bus.in_rs2_s   = 5'd0;
    bus.in_rd_s    = 5'd0;
    bus.in_rd_we   = 1'b0;
    bus.in_payload = 32'd0;
    bus.out_ready  = 1'b1;
    wb_we          = 1'b0;
    wb_rd_s        = 5'd0;
    wb_rd_v        = 32'd0;
  endtask

  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic we, input logic [31:0] pl);
    bus.in_valid   = 1'b1;
    bus.in_rs1_s   = rs1;
    bus.in_rs2_s   = rs2;
    bus.in_rd_s    = rd;
    bus.in_rd_we   = we;
    bus.in_payload = pl;
  endtask

  task automatic writeback(input logic [4:0] rd, input logic [31:0] v);
    wb_we   = 1'b1;
    wb_rd_s = rd;
    wb_rd_v = v;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    rf_clear = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rf_clear = 1'b0;
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
    end
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
`ifdef REGREAD_STALL_CNT_EN
    n_cmp++;
    if (raw_cnt !== 32'd0 || waw_cnt !== 32'd0) begin
      n_fail++; $display("FAIL reset_counters: got raw=%0d waw=%0d want 0/0", raw_cnt, waw_cnt);
    end
`endif
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_basic_read();
    writeback(5'd5, 32'h1234);
    step();
    idle();
    issue(5'd5, 5'd0, 5'd0, 1'b0, 32'h11);
    @(negedge clk);
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL basic_in_ready: got %b want 1", bus.in_ready);
    end
    step();
    idle();
    @(negedge clk);
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_rs1_v !== 32'h1234 || bus.out_rs2_v !== 32'd0
        || bus.out_payload !== 32'h11) begin
      n_fail++; $display("FAIL basic_read: got v=%b rs1=%h rs2=%h pl=%h want 1 1234 0 11",
                         bus.out_valid, bus.out_rs1_v, bus.out_rs2_v, bus.out_payload);
    end
    step();
    @(negedge clk);
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_drain: got out_valid %b want 0", bus.out_valid);
    end
  endtask

  task automatic test_same_cycle_fwd();
    issue(5'd7, 5'd5, 5'd0, 1'b0, 32'h22);
    writeback(5'd7, 32'hDEAD);
    step();
    idle();
    @(negedge clk);
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_rs1_v !== 32'hDEAD || bus.out_rs2_v !== 32'h1234) begin
      n_fail++; $display("FAIL fwd_same_cycle: got v=%b rs1=%h rs2=%h want 1 dead 1234",
                         bus.out_valid, bus.out_rs1_v, bus.out_rs2_v);
    end
    step();
  endtask

  task automatic test_raw_stall();
    issue(5'd0, 5'd0, 5'd3, 1'b1, 32'hA);
    step();
    issue(5'd0, 5'd3, 5'd0, 1'b0, 32'hB);
    @(negedge clk);
    n_cmp++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_rd_s !== 5'd3) begin
      n_fail++; $display("FAIL raw_block1: got ready=%b v=%b rd=%0d want 0 1 3",
                         bus.in_ready, bus.out_valid, bus.out_rd_s);
    end
    step();
    @(negedge clk);
    n_cmp++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL raw_block2: got ready=%b v=%b want 0 0", bus.in_ready, bus.out_valid);
    end
    step();
    writeback(5'd3, 32'h3333);
    @(negedge clk);
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL raw_wb_release: got ready=%b want 1", bus.in_ready);
    end
    step();
    idle();
    issue(5'd3, 5'd0, 5'd0, 1'b0, 32'hC);
    @(negedge clk);
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_rs2_v !== 32'h3333 || bus.out_payload !== 32'hB
        || bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL raw_operand: got v=%b rs2=%h pl=%h ready=%b want 1 3333 b 1",
                         bus.out_valid, bus.out_rs2_v, bus.out_payload, bus.in_ready);
    end
    step();
    idle();
    @(negedge clk);
    n_cmp++;
    if (bus.out_rs1_v !== 32'h3333 || bus.out_payload !== 32'hC) begin
      n_fail++; $display("FAIL raw_after_clear: got rs1=%h pl=%h want 3333 c",
                         bus.out_rs1_v, bus.out_payload);
    end
    step();
  endtask

  task automatic test_waw_set_wins();
    issue(5'd0, 5'd0, 5'd6, 1'b1, 32'h60);
    step();
    issue(5'd0, 5'd0, 5'd6, 1'b1, 32'h61);
    @(negedge clk);
    n_cmp++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL waw_block: got ready=%b want 0", bus.in_ready);
    end
    step();
    writeback(5'd6, 32'h66);
    @(negedge clk);
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL waw_wb_release: got ready=%b want 1", bus.in_ready);
    end
    step();
    idle();
    issue(5'd6, 5'd0, 5'd0, 1'b0, 32'h62);
    @(negedge clk);
    n_cmp++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL waw_set_wins: got ready=%b want 0", bus.in_ready);
    end
    step();
    writeback(5'd6, 32'h77);
    step();
    idle();
    @(negedge clk);
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_rs1_v !== 32'h77 || bus.out_payload !== 32'h62) begin
      n_fail++; $display("FAIL waw_operand: got v=%b rs1=%h pl=%h want 1 77 62",
                         bus.out_valid, bus.out_rs1_v, bus.out_payload);
    end
`ifdef REGREAD_STALL_CNT_EN
    n_cmp++;
    if (raw_cnt !== 32'd3 || waw_cnt !== 32'd1) begin
      n_fail++; $display("FAIL stall_counters: got raw=%0d waw=%0d want 3/1", raw_cnt, waw_cnt);
    end
`endif
    step();
  endtask

  task automatic test_stall_track();
    bus.out_ready = 1'b0;
    issue(5'd9, 5'd0, 5'd0, 1'b0, 32'h9);
    step();
    idle();
    bus.out_ready = 1'b0;
    writeback(5'd9, 32'd1);
    @(negedge clk);
    n_cmp++;
    if (bus.out_valid !== 1'b1 || regf_rs1_s !== 5'd9) begin
      n_fail++; $display("FAIL stall_readdr: got v=%b addr=%0d want 1 9", bus.out_valid, regf_rs1_s);
    end
    step();
    writeback(5'd9, 32'd2);
    issue(5'd1, 5'd2, 5'd0, 1'b0, 32'hEE);
    @(negedge clk);
    n_cmp++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL stall_in_ready: got %b want 0", bus.in_ready);
    end
    step();
    idle();
    bus.out_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.out_rs1_v !== 32'd2 || bus.out_payload !== 32'h9) begin
      n_fail++; $display("FAIL stall_track_fwd: got rs1=%h pl=%h want 2 9", bus.out_rs1_v, bus.out_payload);
    end
    step();
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_rs1_v !== 32'd2 || bus.out_payload !== 32'h9) begin
      n_fail++; $display("FAIL stall_release: got v=%b rs1=%h pl=%h want 1 2 9",
                         bus.out_valid, bus.out_rs1_v, bus.out_payload);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int valid_cycles = 0;
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) issue(5'(10 + i), 5'd5, 5'(20 + i), 1'b1, 32'h100 + 32'(i));
      else idle();
      @(negedge clk);
      if (i < 8) begin
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
          n_fail++; $display("FAIL stream_ready[%0d]: got %b want 1", i, bus.in_ready);
        end
      end
      if (i >= 1) begin
        if (bus.out_valid === 1'b1) valid_cycles++;
        n_cmp++;
        if (bus.out_payload !== 32'h100 + 32'(i - 1) || bus.out_rs1_v !== (32'hA500_000A + 32'(i - 1))
            || bus.out_rs2_v !== 32'h1234) begin
          n_fail++; $display("FAIL stream_slot[%0d]: got pl=%h rs1=%h rs2=%h want %h %h 1234", i - 1,
                             bus.out_payload, bus.out_rs1_v, bus.out_rs2_v,
                             32'h100 + 32'(i - 1), 32'hA500_000A + 32'(i - 1));
        end
      end
      step();
    end
    n_cmp++;
    if (valid_cycles != 8) begin
      n_fail++; $display("FAIL stream_valid_cycles: got %0d want 8", valid_cycles);
    end
  endtask

  task automatic test_reset_midflight();
    bus.out_ready = 1'b0;
    issue(5'd0, 5'd0, 5'd4, 1'b1, 32'h4);
    step();
    idle();
    bus.out_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.out_valid !== 1'b1) begin
      n_fail++; $display("FAIL midreset_pre: got out_valid %b want 1", bus.out_valid);
    end
    #2 rst = 1'b0;
    #1;
    issue(5'd4, 5'd0, 5'd0, 1'b0, 32'h44);
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL midreset_async: got v=%b ready=%b want 0 1", bus.out_valid, bus.in_ready);
    end
`ifdef REGREAD_STALL_CNT_EN
    n_cmp++;
    if (raw_cnt !== 32'd0 || waw_cnt !== 32'd0) begin
      n_fail++; $display("FAIL midreset_counters: got raw=%0d waw=%0d want 0/0", raw_cnt, waw_cnt);
    end
`endif
    step();
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL midreset_issue: got ready=%b v=%b want 1 0", bus.in_ready, bus.out_valid);
    end
    step();
    idle();
    @(negedge clk);
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_rs1_v !== 32'hA500_0004 || bus.out_payload !== 32'h44) begin
      n_fail++; $display("FAIL midreset_result: got v=%b rs1=%h pl=%h want 1 a5000004 44",
                         bus.out_valid, bus.out_rs1_v, bus.out_payload);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_same_cycle_fwd();
    test_raw_stall();
    test_waw_set_wins();
    test_stall_track();
    test_back_to_back();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
